// File: rtl/mc_sc_fifo.sv
// Single-clock multi-channel FIFO: CHANNELS queues share one memory, each with its own pointers and exact count.
// Optional sticky overflow/underflow flags are built only when MC_SC_FIFO_OVF_UDF_EN is defined.
module mc_sc_fifo #(
  parameter int    DWIDTH       = 8,
  parameter int    AWIDTH       = 4,
  parameter int    CHANNELS     = 4,
  parameter string SHOWAHEAD    = "ON",
  parameter int    ALMOST_FULL  = 12,
  parameter int    ALMOST_EMPTY = 2,
  localparam int   CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                            clk_i,
  input  logic                            aclr_n_i,
  input  logic                            wr_req_i,
  input  logic [CW-1:0]                   wr_ch_i,
  input  logic [DWIDTH-1:0]               data_i,
  input  logic                            rd_req_i,
  input  logic [CW-1:0]                   rd_ch_i,
  output logic [DWIDTH-1:0]               q_o,
  output logic                            q_valid_o,
  output logic [CHANNELS-1:0]             empty_o,
  output logic [CHANNELS-1:0]             full_o,
  output logic [CHANNELS-1:0]             almost_empty_o,
  output logic [CHANNELS-1:0]             almost_full_o,
  output logic [CHANNELS*(AWIDTH+1)-1:0]  usedw_o,
  output logic [CHANNELS-1:0]             ovf_o,
  output logic [CHANNELS-1:0]             udf_o
);

  localparam int              DEPTH    = 1 << AWIDTH;
  localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);

  logic [DWIDTH-1:0] mem_q   [CHANNELS][DEPTH];
  logic [AWIDTH-1:0] wptr_q  [CHANNELS];
  logic [AWIDTH-1:0] rptr_q  [CHANNELS];
  logic [AWIDTH:0]   usedw_q [CHANNELS];
  logic [AWIDTH:0]   usedw_d [CHANNELS];

  logic [CHANNELS-1:0] empty, full, wr_sel, rd_sel, wr_hit, rd_hit;
  logic [DWIDTH-1:0]   head;
  logic                head_valid;

  // Channel matching by equality makes an out-of-range index select nothing.
  always_comb begin
    head       = '0;
    head_valid = 1'b0;
    usedw_o    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_sel[c]         = wr_req_i && (wr_ch_i == CW'(c));
      rd_sel[c]         = rd_req_i && (rd_ch_i == CW'(c));
      empty[c]          = (usedw_q[c] == '0);
      full[c]           = (usedw_q[c] == FULL_CNT);
      wr_hit[c]         = wr_sel[c] && !full[c];
      rd_hit[c]         = rd_sel[c] && !empty[c];
      almost_full_o[c]  = (int'(usedw_q[c]) >= ALMOST_FULL);
      almost_empty_o[c] = (int'(usedw_q[c]) <= ALMOST_EMPTY);
      usedw_o[c*(AWIDTH+1) +: AWIDTH+1] = usedw_q[c];
      if (rd_ch_i == CW'(c)) begin
        head       = mem_q[c][rptr_q[c]];
        head_valid = !empty[c];
      end
      unique case ({wr_hit[c], rd_hit[c]})
        2'b10:   usedw_d[c] = usedw_q[c] + 1'b1;
        2'b01:   usedw_d[c] = usedw_q[c] - 1'b1;
        default: usedw_d[c] = usedw_q[c];
      endcase
    end
  end

  assign empty_o = empty;
  assign full_o  = full;

  always_ff @(posedge clk_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        usedw_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_hit[c]) wptr_q[c] <= wptr_q[c] + 1'b1;
        if (rd_hit[c]) rptr_q[c] <= rptr_q[c] + 1'b1;
        usedw_q[c] <= usedw_d[c];
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_hit[c]) mem_q[c][wptr_q[c]] <= data_i;
    end
  end

  if (SHOWAHEAD == "OFF") begin : g_reg_out
    logic [DWIDTH-1:0] q_q;
    logic              q_valid_q;
    always_ff @(posedge clk_i or negedge aclr_n_i) begin
      if (!aclr_n_i) begin
        q_q       <= '0;
        q_valid_q <= 1'b0;
      end else begin
        q_valid_q <= rd_req_i && head_valid;
        if (rd_req_i && head_valid) q_q <= head;
      end
    end
    assign q_o       = q_q;
    assign q_valid_o = q_valid_q;
  end else begin : g_showahead
    // Masked while empty so q_o reads 0 out of reset instead of stale memory.
    assign q_o       = head_valid ? head : '0;
    assign q_valid_o = head_valid;
  end

`ifdef MC_SC_FIFO_OVF_UDF_EN
  logic [CHANNELS-1:0] ovf_q, udf_q;
  always_ff @(posedge clk_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      ovf_q <= ovf_q | (wr_sel & full);
      udf_q <= udf_q | (rd_sel & empty);
    end
  end
  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`else
  assign ovf_o = '0;
  assign udf_o = '0;
`endif

endmodule

// File: tb/tb_mc_sc_fifo.sv
// Bench for mc_sc_fifo: a showahead and a registered-output instance share stimulus and a queue-based reference model.
module tb_mc_sc_fifo;
  localparam int CH = 4, DEPTH = 16, UW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aclr_n = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic [1:0]  wr_ch = '0, rd_ch = '0;
  logic [7:0]  data = '0;

  logic [7:0]       q, off_q;
  logic             qv, off_qv;
  logic [CH-1:0]    empty, full, ae, af, ovf, udf;
  logic [CH-1:0]    off_empty, off_full, off_ae, off_af, off_ovf, off_udf;
  logic [CH*UW-1:0] usedw, off_usedw;

  mc_sc_fifo #(.SHOWAHEAD("ON")) dut (
    .clk_i(clk), .aclr_n_i(aclr_n), .wr_req_i(wr_req), .wr_ch_i(wr_ch), .data_i(data),
    .rd_req_i(rd_req), .rd_ch_i(rd_ch), .q_o(q), .q_valid_o(qv), .empty_o(empty), .full_o(full),
    .almost_empty_o(ae), .almost_full_o(af), .usedw_o(usedw), .ovf_o(ovf), .udf_o(udf));

  mc_sc_fifo #(.SHOWAHEAD("OFF")) dut_off (
    .clk_i(clk), .aclr_n_i(aclr_n), .wr_req_i(wr_req), .wr_ch_i(wr_ch), .data_i(data),
    .rd_req_i(rd_req), .rd_ch_i(rd_ch), .q_o(off_q), .q_valid_o(off_qv), .empty_o(off_empty),
    .full_o(off_full), .almost_empty_o(off_ae), .almost_full_o(off_af), .usedw_o(off_usedw),
    .ovf_o(off_ovf), .udf_o(off_udf));

  int n_tests = 0, n_fail = 0;

  // Reference model: one queue per channel, plus registered-output and sticky-flag state.
  logic [7:0]    mq [CH][$];
  logic [CH-1:0] m_ovf = '0, m_udf = '0;
  logic [7:0]    m_offq = '0;
  logic          m_offv = 1'b0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    logic [4:0] exp_used1;
    logic [3:0] exp_empty;
    logic       chk_q;
    logic [7:0] exp_q;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) mq[c].delete();
    m_ovf  = '0;
    m_udf  = '0;
    m_offq = '0;
    m_offv = 1'b0;
  endtask

  task automatic model_edge();
    int  ws, rs;
    bit  wok, rok;
    ws  = mq[wr_ch].size();
    rs  = mq[rd_ch].size();
    wok = wr_req && (ws < DEPTH);
    rok = rd_req && (rs > 0);
`ifdef MC_SC_FIFO_OVF_UDF_EN
    if (wr_req && ws == DEPTH) m_ovf[wr_ch] = 1'b1;
    if (rd_req && rs == 0)     m_udf[rd_ch] = 1'b1;
`endif
    m_offv = rok;
    if (rok) m_offq = mq[rd_ch].pop_front();
    if (wok) mq[wr_ch].push_back(data);
  endtask

  task automatic check_all();
    logic [CH*UW-1:0] eu;
    logic [CH-1:0]    ee, ef, eae, eaf;
    for (int c = 0; c < CH; c++) begin
      eu[c*UW +: UW] = UW'(mq[c].size());
      ee[c]  = (mq[c].size() == 0);
      ef[c]  = (mq[c].size() == DEPTH);
      eae[c] = (mq[c].size() <= 2);
      eaf[c] = (mq[c].size() >= 12);
    end
    check("usedw", usedw, eu);
    check("empty", empty, ee);
    check("full", full, ef);
    check("almost_empty", ae, eae);
    check("almost_full", af, eaf);
    check("q_valid_on", qv, mq[rd_ch].size() != 0);
    if (mq[rd_ch].size() != 0) check("q_on", q, mq[rd_ch][0]);
    check("off_usedw", off_usedw, eu);
    check("q_valid_off", off_qv, m_offv);
    check("q_off", off_q, m_offq);
    check("ovf", ovf, m_ovf);
    check("udf", udf, m_udf);
    check("off_ovf", off_ovf, m_ovf);
    check("off_udf", off_udf, m_udf);
  endtask

  task automatic step(input logic w, input logic [1:0] wc, input logic [7:0] d,
                      input logic r, input logic [1:0] rc);
    @(negedge clk);
    wr_req = w; wr_ch = wc; data = d; rd_req = r; rd_ch = rc;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_reset_values();
    check("rst_usedw", usedw, '0);
    check("rst_empty", empty, 4'hF);
    check("rst_full", full, 4'h0);
    check("rst_almost_empty", ae, 4'hF);
    check("rst_almost_full", af, 4'h0);
    check("rst_q", q, 8'h00);
    check("rst_q_valid", qv, 1'b0);
    check("rst_off_q", off_q, 8'h00);
    check("rst_off_q_valid", off_qv, 1'b0);
    check("rst_ovf", ovf, 4'h0);
    check("rst_udf", udf, 4'h0);
  endtask

  // Reset is asserted between edges so the asynchronous path is what gets observed.
  task automatic apply_reset();
    @(negedge clk);
    #2 aclr_n = 1'b0;
    #1 check_reset_values();
    model_clear();
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (2) @(negedge clk);
    aclr_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'h11, 5'd1, 4'b1101, 1'b1, 8'h11};
    tbl[1] = '{1'b1, 1'b0, 8'h22, 5'd2, 4'b1101, 1'b1, 8'h11};
    tbl[2] = '{1'b1, 1'b0, 8'h33, 5'd3, 4'b1101, 1'b1, 8'h11};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 5'd2, 4'b1101, 1'b1, 8'h22};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 5'd1, 4'b1101, 1'b1, 8'h33};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 5'd0, 4'b1111, 1'b0, 8'h00};

    #3;
    check_reset_values();
    @(negedge clk);
    aclr_n = 1'b1;

    // Basic ordering on channel 1
    foreach (tbl[i]) begin
      step(tbl[i].wr, 2'd1, tbl[i].d, tbl[i].rd, 2'd1);
      check("tbl_usedw1", usedw[1*UW +: UW], tbl[i].exp_used1);
      check("tbl_empty", empty, tbl[i].exp_empty);
      if (tbl[i].chk_q) check("tbl_q", q, tbl[i].exp_q);
    end

    // Fill channel 0, overflow attempt, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 2'd0, 8'(8'h40 + i), 1'b0, 2'd0);
      check("fill_almost_full", af[0], (i + 1) >= 12);
    end
    check("fill_full", full[0], 1'b1);
    step(1'b1, 2'd0, 8'hEE, 1'b0, 2'd0);
    check("overfill_usedw", usedw[0 +: UW], 5'd16);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_q", q, 8'(8'h40 + i));
      step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    end
    check("drain_empty", empty[0], 1'b1);

    // Interleaved channels 2 and 3
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'd2, 8'(8'hA0 + i), 1'b0, 2'd2);
      step(1'b1, 2'd3, 8'(8'hB0 + i), 1'b0, 2'd2);
    end
    check("inter_usedw01", usedw[0 +: 2*UW], '0);
    for (int i = 0; i < 5; i++) begin
      check("inter_q2", q, 8'(8'hA0 + i));
      step(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
    end
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd3);
    for (int i = 0; i < 5; i++) begin
      check("inter_q3", q, 8'(8'hB0 + i));
      step(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
    end

    // Simultaneous write+read on a full channel: read wins, write dropped
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd0, 8'(8'h60 + i), 1'b0, 2'd0);
    step(1'b1, 2'd0, 8'hCC, 1'b1, 2'd0);
    check("full_wr_rd_usedw", usedw[0 +: UW], 5'd15);
    for (int i = 1; i < DEPTH; i++) begin
      check("full_wr_rd_q", q, 8'(8'h60 + i));
      step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    end
    // Simultaneous write+read on an empty channel: write wins, read ignored
    step(1'b1, 2'd0, 8'hDD, 1'b1, 2'd0);
    check("empty_wr_rd_usedw", usedw[0 +: UW], 5'd1);
    check("empty_wr_rd_q", q, 8'hDD);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);

    // Registered-output instance: one-cycle valid pulse after the pop
    step(1'b1, 2'd1, 8'h5A, 1'b0, 2'd1);
    check("off_pre_valid", off_qv, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
    check("off_pop_valid", off_qv, 1'b1);
    check("off_pop_q", off_q, 8'h5A);
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd1);
    check("off_post_valid", off_qv, 1'b0);
    check("off_hold_q", off_q, 8'h5A);

    // Underflow on empty channel 3, sticky
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
`ifdef MC_SC_FIFO_OVF_UDF_EN
    check("udf3_set", udf[3], 1'b1);
`else
    check("udf3_tied", udf[3], 1'b0);
`endif
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd3);
`ifdef MC_SC_FIFO_OVF_UDF_EN
    check("udf3_sticky", udf[3], 1'b1);
`else
    check("udf3_tied_again", udf[3], 1'b0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), 8'($urandom),
           1'($urandom_range(0, 9) < 5), 2'($urandom_range(0, 3)));
    end

    // Mid-burst asynchronous reset, then first write after release
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 8'(8'h90 + i), 1'b0, 2'd0);
    apply_reset();
    step(1'b1, 2'd0, 8'h77, 1'b0, 2'd0);
    check("post_rst_usedw0", usedw[0 +: UW], 5'd1);
    check("post_rst_q", q, 8'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
